trigger_capture_ctrl: RTL

Trigger and capture controller for the logic analyzer. It sits directly downstream of the 2-stage input synchronizer. On each sample strobe it evaluates a level/edge trigger on the synchronized channel bus, runs the pre-trigger / armed / post-trigger sequence, and emits registered write strobes plus data to the sample buffer.

---
 rtl/trigger_capture_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/trigger_capture_ctrl.sv
// Logic-analyzer trigger/capture sequencer: pre-trigger fill, armed level/edge match, post-trigger fill.
// Captures are registered one cycle after sample_en; there is no backpressure, so every qualifying strobe is written.
module trigger_capture_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sample_en,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] edge_mask,
    input  logic [DATA_WIDTH-1:0] edge_pol,
    input  logic [CNT_WIDTH-1:0]  pretrig_len,
    input  logic [CNT_WIDTH-1:0]  posttrig_len,
    output logic [2:0]            state,
    output logic                  capture_en,
    output logic [DATA_WIDTH-1:0] capture_data,
    output logic                  capture_trig,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRETRIG = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t cur_state, nxt_state;

    logic [DATA_WIDTH-1:0] cfg_trig_mask, cfg_trig_value, cfg_edge_mask, cfg_edge_pol;
    logic [CNT_WIDTH-1:0]  cfg_pretrig_len, cfg_posttrig_len;
    logic [CNT_WIDTH-1:0]  pre_cnt, post_cnt, pre_next, post_next;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;

    logic arm_ok, take, level_hit, edge_hit, trig_hit;

    assign arm_ok = arm && !abort && ((cur_state == S_IDLE) || (cur_state == S_DONE));
    assign take   = sample_en && !abort &&
                    ((cur_state == S_PRETRIG) || (cur_state == S_ARMED) || (cur_state == S_POST));

    assign level_hit = ((data_in ^ cfg_trig_value) & cfg_trig_mask) == '0;
    // Every edge-masked bit must have toggled and landed on its requested polarity.
    assign edge_hit  = (cfg_edge_mask == '0) ||
                       (prev_valid &&
                        (((prev ^ data_in) & cfg_edge_mask) == cfg_edge_mask) &&
                        (((data_in ^ cfg_edge_pol) & cfg_edge_mask) == '0));
    assign trig_hit  = take && (cur_state == S_ARMED) && level_hit && edge_hit;

    assign pre_next  = pre_cnt + CNT_WIDTH'(1);
    assign post_next = post_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_IDLE;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (abort) begin
            nxt_state = S_IDLE;
        end else if (arm_ok) begin
            nxt_state = (pretrig_len != '0) ? S_PRETRIG : S_ARMED;
        end else begin
            case (cur_state)
                S_IDLE:    nxt_state = S_IDLE;
                S_PRETRIG: if (take && (pre_next == cfg_pretrig_len)) nxt_state = S_ARMED;
                S_ARMED:   if (trig_hit) nxt_state = (cfg_posttrig_len == '0) ? S_DONE : S_POST;
                S_POST:    if (take && (post_next == cfg_posttrig_len)) nxt_state = S_DONE;
                S_DONE:    nxt_state = S_DONE;
                default:   nxt_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        state = cur_state;
        done  = (cur_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_trig_mask    <= '0;
            cfg_trig_value   <= '0;
            cfg_edge_mask    <= '0;
            cfg_edge_pol     <= '0;
            cfg_pretrig_len  <= '0;
            cfg_posttrig_len <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            prev             <= '0;
            prev_valid       <= 1'b0;
            capture_en       <= 1'b0;
            capture_trig     <= 1'b0;
            capture_data     <= '0;
        end else begin
            capture_en   <= take;
            capture_trig <= trig_hit;
            if (arm_ok) begin
                cfg_trig_mask    <= trig_mask;
                cfg_trig_value   <= trig_value;
                cfg_edge_mask    <= edge_mask;
                cfg_edge_pol     <= edge_pol;
                cfg_pretrig_len  <= pretrig_len;
                cfg_posttrig_len <= posttrig_len;
                pre_cnt          <= '0;
                post_cnt         <= '0;
                prev_valid       <= 1'b0;
            end
            if (take) begin
                capture_data <= data_in;
                prev         <= data_in;
                prev_valid   <= 1'b1;
                if (cur_state == S_PRETRIG) pre_cnt  <= pre_next;
                if (cur_state == S_POST)    post_cnt <= post_next;
            end
        end
    end

endmodule
